// File: rtl/uart_tx_sched_pkg.sv
// rtl/uart_tx_sched_pkg.sv - shared types and constants for the UART TX scheduler
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_GAP       = 2'd3
    } state_e;

    localparam int UART_OSR   = 16;
    localparam int FRAME_BITS = 10;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rtl/uart_tx_sched_rr_arbiter.sv - combinational round-robin arbiter
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] last_grant_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] grant_idx_o,
    output logic             any_req_o
);

    int idx;

    // Walk from the farthest slot back to last+1 so the nearest requester wins.
    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        any_req_o   = 1'b0;
        idx         = 0;
        for (int off = N_REQ; off >= 1; off--) begin
            idx = (int'(last_grant_i) + off) % N_REQ;
            if (req_i[idx]) begin
                grant_o      = '0;
                grant_o[idx] = 1'b1;
                grant_idx_o  = IDX_W'(idx);
                any_req_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_sched.sv
// rtl/uart_tx_sched.sv - round-robin scheduler sharing one UART transmitter
module uart_tx_sched
    import uart_tx_sched_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int GAP_TICKS     = 16,
    parameter int TIMEOUT_TICKS = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    tick,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [8*N_REQ-1:0]      req_data,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_start,
    output logic [7:0]              tx_data,
    input  logic                    tx_done,
    output logic [clog2(N_REQ)-1:0] grant_id,
    output logic                    busy,
    output logic                    err_timeout
);

    localparam int IDX_W   = clog2(N_REQ);
    localparam int CNT_MAX = (GAP_TICKS > TIMEOUT_TICKS) ? GAP_TICKS : TIMEOUT_TICKS;
    localparam int CNT_W   = clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] GAP_CNT = CNT_W'(GAP_TICKS);
    localparam logic [CNT_W-1:0] TO_CNT  = CNT_W'(TIMEOUT_TICKS);

    state_e           state_q, state_d;
    logic [7:0]       data_q, data_d;
    logic [IDX_W-1:0] gid_q, gid_d;
    logic [IDX_W-1:0] last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [N_REQ-1:0] arb_grant;
    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [7:0]       sel_byte;
    logic [CNT_W-1:0] cnt_inc;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req_i        (req_valid),
        .last_grant_i (last_q),
        .grant_o      (arb_grant),
        .grant_idx_o  (arb_idx),
        .any_req_o    (arb_any)
    );

    // Only the granted lane is ever read, so idle lanes may carry garbage.
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (arb_grant[i]) begin
                sel_byte = req_data[8*i +: 8];
            end
        end
    end

    assign cnt_inc = (tick && (cnt_q != CNT_SAT)) ? cnt_q + 1'b1 : cnt_q;

    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        gid_d     = gid_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        err_d     = 1'b0;
        req_ready = '0;
        tx_start  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (arb_any) begin
                    req_ready = arb_grant;
                    data_d    = sel_byte;
                    gid_d     = arb_idx;
                    last_d    = arb_idx;
                    state_d   = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                tx_start = 1'b1;
                cnt_d    = '0;
                state_d  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                cnt_d = cnt_inc;
                // A done on the final watchdog tick still counts as a good frame.
                if (tx_done) begin
                    cnt_d   = '0;
                    state_d = (GAP_TICKS == 0) ? ST_IDLE : ST_GAP;
                end else if (cnt_inc == TO_CNT) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                cnt_d = cnt_inc;
                if (cnt_inc == GAP_CNT) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            gid_q   <= '0;
            last_q  <= IDX_W'(N_REQ - 1);
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            gid_q   <= gid_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign tx_data     = data_q;
    assign grant_id    = gid_q;
    assign busy        = (state_q != ST_IDLE);
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_sched.sv
// tb/tb_uart_tx_sched.sv - self-checking bench for uart_tx_sched
module tb_uart_tx_sched;

    localparam int N     = 4;
    localparam int GAP   = 16;
    localparam int TO    = 256;
    localparam int FRAME = 160;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           tick = 1'b0;
    logic           tx_done = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;

    logic [N-1:0] req_ready, req_ready0;
    logic         tx_start, tx_start0;
    logic [7:0]   tx_data, tx_data0;
    logic [1:0]   grant_id, grant_id0;
    logic         busy, busy0;
    logic         err, err0;

    uart_tx_sched #(.N_REQ(N), .GAP_TICKS(GAP), .TIMEOUT_TICKS(TO)) dut (
        .clk(clk), .rst(rst), .tick(tick), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data), .tx_done(tx_done),
        .grant_id(grant_id), .busy(busy), .err_timeout(err)
    );

    uart_tx_sched #(.N_REQ(N), .GAP_TICKS(0), .TIMEOUT_TICKS(TO)) dut0 (
        .clk(clk), .rst(rst), .tick(tick), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready0), .tx_start(tx_start0), .tx_data(tx_data0), .tx_done(tx_done),
        .grant_id(grant_id0), .busy(busy0), .err_timeout(err0)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Stimulus driver: tick generator plus a transmitter that answers each start.
    int tick_per = 1;
    bit xm_en    = 1'b1;
    int xm_frame = FRAME;
    bit xm_act   = 1'b0;
    int xm_cnt   = 0;
    int st_gid[$];
    int st_cyc[$];
    int st_data[$];

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        tick    = ((cyc % tick_per) == 0);
        tx_done = 1'b0;
        if (rst) begin
            xm_act = 1'b0;
        end else if (tx_start) begin
            xm_act = xm_en;
            xm_cnt = 0;
            st_gid.push_back(int'(grant_id));
            st_cyc.push_back(cyc);
            st_data.push_back(int'(tx_data));
        end else if (xm_act && tick) begin
            xm_cnt++;
            if (xm_cnt == xm_frame) begin
                tx_done = 1'b1;
                xm_act  = 1'b0;
            end
        end
    endtask

    task automatic clear_q();
        st_gid.delete();
        st_cyc.delete();
        st_data.delete();
    endtask

    task automatic wait_idle(input string name);
        for (int k = 0; k < 1200 && busy; k++) step();
        check(name, int'(busy), 0);
    endtask

    // Transaction-level model: one owned frame described by its accept cycle,
    // the ticks seen while waiting, and the ticks seen after done.
    bit m_g    = 1'b0;
    int m_acc  = 0;
    int m_done = -1;
    int m_tw   = 0;
    int m_tg   = 0;
    int m_last = N - 1;
    int m_gid  = 0;
    int m_data = 0;
    bit m_err  = 1'b0;
    int pick;
    int exp_ready;

    function automatic int rr_pick(input int last, input logic [N-1:0] v);
        for (int k = 1; k <= N; k++) begin
            if (v[(last + k) % N]) return (last + k) % N;
        end
        return -1;
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            m_g = 1'b0; m_last = N - 1; m_gid = 0; m_data = 0; m_err = 1'b0;
            check("rst_busy", int'(busy), 0);
            check("rst_start", int'(tx_start), 0);
            check("rst_err", int'(err), 0);
            check("rst_data", int'(tx_data), 0);
            check("rst_gid", int'(grant_id), 0);
        end else begin
            pick      = rr_pick(m_last, req_valid);
            exp_ready = (!m_g && pick >= 0) ? (1 << pick) : 0;
            check("m_ready", int'(req_ready), exp_ready);
            check("m_busy", int'(busy), int'(m_g));
            check("m_start", int'(tx_start), int'(m_g && cyc == m_acc + 1));
            check("m_data", int'(tx_data), m_data);
            check("m_gid", int'(grant_id), m_gid);
            check("m_err", int'(err), int'(m_err));
            m_err = 1'b0;
            if (!m_g) begin
                if (pick >= 0) begin
                    m_g = 1'b1; m_acc = cyc; m_done = -1; m_tw = 0; m_tg = 0;
                    m_gid = pick; m_last = pick; m_data = int'(req_data[8*pick +: 8]);
                end
            end else if (cyc > m_acc + 1) begin
                if (m_done < 0) begin
                    if (tx_done) begin
                        if (GAP == 0) m_g = 1'b0;
                        else m_done = cyc;
                    end else if (tick) begin
                        m_tw++;
                        if (m_tw == TO) begin
                            m_g = 1'b0;
                            m_err = 1'b1;
                        end
                    end
                end else if (tick) begin
                    m_tg++;
                    if (m_tg == GAP) m_g = 1'b0;
                end
            end
        end
    end

    task automatic mid_reset(input int hold, input string tag);
        req_valid = 4'b1000;
        req_data  = 32'hEE000000;
        clear_q();
        for (int k = 0; k < 20 && st_gid.size() == 0; k++) step();
        check({tag, "_start"}, st_gid.size(), 1);
        req_valid = '0;
        repeat (hold) step();
        check({tag, "_busy_before"}, int'(busy), 1);
        #2 rst = 1'b1;
        #1;
        check({tag, "_async_busy"}, int'(busy), 0);
        check({tag, "_async_start"}, int'(tx_start), 0);
        check({tag, "_async_data"}, int'(tx_data), 0);
        check({tag, "_async_gid"}, int'(grant_id), 0);
        check({tag, "_async_err"}, int'(err), 0);
        repeat (2) step();
        req_valid = 4'b1111;
        req_data  = 32'h33323130;
        clear_q();
        step();
        rst = 1'b0;
        for (int k = 0; k < 20 && st_gid.size() == 0; k++) step();
        check({tag, "_relaunch"}, st_gid.size(), 1);
        check({tag, "_first_gid"}, st_gid[0], 0);
        check({tag, "_first_data"}, st_data[0], 8'h30);
        req_valid = '0;
        wait_idle({tag, "_idle"});
    endtask

    int exp_ord[5] = '{0, 1, 2, 3, 0};
    int n_busy;
    int n_err;
    int n_tick;
    bit seen;

    initial begin
        repeat (3) step();

        // Reset release with a single waiting requester
        req_valid = 4'b0001;
        req_data  = 32'h000000A5;
        step();
        rst = 1'b0;
        #1;
        check("t1_ready", int'(req_ready), 1);
        step();
        check("t1_start", int'(tx_start), 1);
        check("t1_data", int'(tx_data), 8'hA5);
        check("t1_gid", int'(grant_id), 0);
        req_valid = '0;
        n_busy = 1;
        for (int k = 0; k < 400; k++) begin
            step();
            if (busy) n_busy++;
            else break;
        end
        check("t1_busy_cycles", n_busy, 1 + FRAME + GAP);

        // All four requesters valid continuously
        step(); rst = 1'b1; repeat (2) step();
        req_valid = 4'b1111;
        req_data  = 32'h13121110;
        clear_q();
        step(); rst = 1'b0;
        for (int k = 0; k < 1500 && st_gid.size() < 5; k++) step();
        req_valid = '0;
        check("t2_starts", st_gid.size(), 5);
        for (int k = 0; k < 5 && k < st_gid.size(); k++) begin
            check("t2_order", st_gid[k], exp_ord[k]);
            check("t2_data", st_data[k], 8'h10 + exp_ord[k]);
            if (k > 0) check("t2_spacing", st_cyc[k] - st_cyc[k-1], FRAME + GAP + 2);
        end
        wait_idle("t2_idle");

        // Zero-gap instance returns to IDLE straight after done
        step(); rst = 1'b1; repeat (2) step();
        req_valid = 4'b0100;
        req_data  = 32'h005C0000;
        step(); rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            seen = tx_done;
        end
        check("t3_done_seen", int'(seen), 1);
        check("t3_busy0_at_done", int'(busy0), 1);
        check("t3_data0", int'(tx_data0), 8'h5C);
        step();
        check("t3_ready0", int'(req_ready0), 4'b0100);
        check("t3_busy0", int'(busy0), 0);
        req_valid = '0;
        wait_idle("t3_idle");

        // Watchdog abort with a slower tick
        xm_en    = 1'b0;
        tick_per = 3;
        req_valid = 4'b0010;
        req_data  = 32'h00004200;
        clear_q();
        n_tick = 0;
        seen   = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            step();
            if (st_gid.size() > 0) req_valid = '0;
            if (err) begin
                seen = 1'b1;
                break;
            end
            if (st_cyc.size() > 0 && cyc > st_cyc[0] && tick) n_tick++;
        end
        check("t4_err_seen", int'(seen), 1);
        check("t4_wait_ticks", n_tick, TO);
        check("t4_idle_at_err", int'(busy), 0);
        n_err = 1;
        repeat (20) begin
            step();
            if (err) n_err++;
        end
        check("t4_err_pulses", n_err, 1);
        xm_en    = 1'b1;
        tick_per = 1;
        req_valid = 4'b0001;
        req_data  = 32'h00000077;
        clear_q();
        for (int k = 0; k < 20 && st_gid.size() == 0; k++) step();
        req_valid = '0;
        check("t4_next_start", st_gid.size(), 1);
        check("t4_next_gid", st_gid[0], 0);
        check("t4_next_data", st_data[0], 8'h77);
        wait_idle("t4_idle");

        // Done on the same cycle as the final watchdog tick
        xm_frame  = TO;
        req_valid = 4'b0100;
        req_data  = 32'h00990000;
        clear_q();
        for (int k = 0; k < 20 && st_gid.size() == 0; k++) step();
        req_valid = '0;
        seen = 1'b0;
        for (int k = 0; k < 400 && !seen; k++) begin
            step();
            seen = tx_done;
        end
        check("t5_done_seen", int'(seen), 1);
        step();
        check("t5_gap_busy", int'(busy), 1);
        check("t5_no_err", int'(err), 0);
        wait_idle("t5_idle");
        xm_frame = FRAME;

        // Asynchronous reset in WAIT_DONE and in GAP
        mid_reset(20, "t6_wait");
        mid_reset(FRAME + 10, "t6_gap");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got still running expected finished");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

endmodule
